// File: rtl/iir1_filter.sv
// iir1_filter: multi-channel first-order IIR (bilinear LPF/HPF) for the guitar path.
// Coefficients come from the pot frequency via an on-block restoring divider;
// samples are filtered one per clock with per-channel history.
// Build option: define IIR_ROUND_EN to round half up before the output shift
// (default build floors).
module iir1_filter #(
  parameter int unsigned N  = 10,
  parameter int unsigned CH = 2,
  parameter int unsigned F  = 10,
  parameter int unsigned K  = 19120,
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    f,
  input  logic           filt_type,
  input  logic           coef_load,
  output logic           coef_busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [N-1:0]   x_in,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [N-1:0]   y_out
);

  localparam int unsigned DW    = $clog2(K + 65536) + 1;
  localparam int unsigned RW    = DW - 1;
  localparam int unsigned CNTW  = $clog2(F + 1);
  localparam int unsigned ACC_W = N + F + 4;
  localparam int          CH_DEPTH = 2 ** CHW;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (N - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIV_B  = 2'd1;
  localparam logic [1:0] DIV_A  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]      state, state_d;
  logic [CNTW-1:0] cnt;
  logic [RW-1:0]   rem;
  logic [F:0]      nsr;
  logic [F-1:0]    quo;
  logic [F:0]      qb, qa;
  logic [15:0]     f_lat;
  logic            type_lat;

  logic [F:0]          coef_b, coef_c;
  logic signed [F+1:0] coef_a;
  logic                ftype;

  logic [DW-1:0] dvsr_c, shift_c, amag_c;
  logic          take_c;
  logic [F:0]    quo_next_c;

  logic signed [N-1:0] hx1 [CH_DEPTH];
  logic signed [N-1:0] hy1 [CH_DEPTH];

  logic signed [N-1:0]     xs_c, x1_c, y1_c, ycl_c;
  logic signed [N:0]       sum_c;
  logic signed [F+1:0]     k_c;
  logic signed [ACC_W-1:0] acc_c, sh_c;
  logic                    ch_ok_c;

  // One restoring-division step: shift in the next numerator bit, subtract if it fits
  always_comb begin
    dvsr_c     = DW'(K) + DW'(f_lat);
    shift_c    = {rem, nsr[F]};
    take_c     = (shift_c >= dvsr_c);
    quo_next_c = {quo, take_c};
    amag_c     = (32'(f_lat) > K) ? (DW'(f_lat) - DW'(K)) : (DW'(K) - DW'(f_lat));
  end

  // Divider sequencing: load -> b quotient -> a quotient -> commit
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (coef_load) state_d = DIV_B;
      DIV_B:   if (cnt == '0) state_d = DIV_A;
      DIV_A:   if (cnt == '0) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, divider datapath and coefficient bank
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      nsr       <= '0;
      quo       <= '0;
      qb        <= '0;
      qa        <= '0;
      f_lat     <= '0;
      type_lat  <= 1'b0;
      coef_b    <= '0;
      coef_a    <= '0;
      coef_c    <= '0;
      ftype     <= 1'b0;
      coef_busy <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      coef_busy <= (state_d != IDLE);
      in_ready  <= (state_d == IDLE);
      case (state)
        IDLE: begin
          if (coef_load) begin
            f_lat    <= f;
            type_lat <= filt_type;
            rem      <= RW'(f >> 1);
            nsr      <= {f[0], {F{1'b0}}};
            quo      <= '0;
            cnt      <= CNTW'(F);
          end
        end
        DIV_B, DIV_A: begin
          rem <= take_c ? RW'(shift_c - dvsr_c) : RW'(shift_c);
          nsr <= nsr << 1;
          quo <= quo_next_c[F-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            if (state == DIV_B) begin
              qb  <= quo_next_c;
              rem <= RW'(amag_c >> 1);
              nsr <= {amag_c[0], {F{1'b0}}};
              quo <= '0;
              cnt <= CNTW'(F);
            end else begin
              qa <= quo_next_c;
            end
          end
        end
        COMMIT: begin
          coef_b <= qb;
          coef_c <= (F + 1)'(2 ** F) - qb;
          coef_a <= (32'(f_lat) > K) ? -$signed({1'b0, qa}) : $signed({1'b0, qa});
          ftype  <= type_lat;
        end
        default: ;
      endcase
    end
  end

  // Channel range check; trivially true when CH fills the index space
  if (CH < 2 ** CHW) begin : g_chk
    assign ch_ok_c = (in_ch < CHW'(CH));
  end else begin : g_all
    assign ch_ok_c = 1'b1;
  end

  // Difference equation, optional rounding, arithmetic shift and clamp
  always_comb begin
    xs_c = $signed({~x_in[N-1], x_in[N-2:0]});
    x1_c = hx1[in_ch];
    y1_c = hy1[in_ch];
    if (ftype) begin
      sum_c = (N + 1)'(xs_c) - (N + 1)'(x1_c);
      k_c   = $signed({1'b0, coef_c});
    end else begin
      sum_c = (N + 1)'(xs_c) + (N + 1)'(x1_c);
      k_c   = $signed({1'b0, coef_b});
    end
    acc_c = ACC_W'(k_c) * ACC_W'(sum_c) + ACC_W'(coef_a) * ACC_W'(y1_c);
`ifdef IIR_ROUND_EN
    acc_c = acc_c + ACC_W'(2 ** (F - 1));
`else
`endif
    sh_c = acc_c >>> F;
    if (sh_c > Y_MAX) begin
      ycl_c = N'(Y_MAX);
    end else if (sh_c < Y_MIN) begin
      ycl_c = N'(Y_MIN);
    end else begin
      ycl_c = N'(sh_c);
    end
  end

  // Output register and per-channel history update
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      y_out     <= {1'b1, {(N - 1){1'b0}}};
      for (int i = 0; i < CH_DEPTH; i++) begin
        hx1[i] <= '0;
        hy1[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid && in_ready && ch_ok_c) begin
        out_valid  <= 1'b1;
        out_ch     <= in_ch;
        y_out      <= {~ycl_c[N-1], ycl_c[N-2:0]};
        hx1[in_ch] <= xs_c;
        hy1[in_ch] <= ycl_c;
      end
    end
  end

endmodule
